tff_down_counter: RTL and testbench



---
 rtl/tff_down_counter_pkg.sv | 19 +
 rtl/tff_down_counter_if.sv | 34 +++
 rtl/tff_down_counter_tff_cell.sv | 25 ++
 rtl/tff_down_counter.sv | 88 ++++++++
 tb/tb_tff_down_counter.sv | 154 +++++++++++++++
 5 files changed

// File: rtl/tff_down_counter_pkg.sv
// Shared definitions for the T-FF down counter: default width, reset value
// and a helper that builds the all-ones terminal count for a given width.
package tff_down_counter_pkg;

    localparam int   DEFAULT_WIDTH = 4;
    localparam int   RESET_VALUE   = 0;
    localparam logic RESET_BIT     = 1'b0;

    // All-ones value for a counter of the given width (at most 32 bits).
    function automatic logic [31:0] count_max(input int width);
        logic [31:0] result;
        result = '0;
        for (int i = 0; i < width && i < 32; i++) begin
            result[i] = 1'b1;
        end
        return result;
    endfunction

endpackage

// File: rtl/tff_down_counter_if.sv
// Control/status bundle for the T-FF down counter. The master drives load,
// load_value and enable; the slave (the counter) returns count, zero, borrow.
interface tff_down_counter_if
    import tff_down_counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic             load;
    logic [WIDTH-1:0] load_value;
    logic             enable;
    logic [WIDTH-1:0] count;
    logic             zero;
    logic             borrow;

    modport master (
        output load,
        output load_value,
        output enable,
        input  count,
        input  zero,
        input  borrow
    );

    modport slave (
        input  load,
        input  load_value,
        input  enable,
        output count,
        output zero,
        output borrow
    );

endinterface

// File: rtl/tff_down_counter_tff_cell.sv
// Single synchronous toggle flip-flop with clear and parallel load.
// Edge priority: clear, then load, then toggle.
module tff_cell
    import tff_down_counter_pkg::*;
(
    input  logic clk,
    input  logic clear,
    input  logic load,
    input  logic d,
    input  logic toggle,
    output logic q
);

    // State bit: clear beats load, load beats toggle, otherwise hold.
    always_ff @(posedge clk) begin
        if (clear) begin
            q <= RESET_BIT;
        end else if (load) begin
            q <= d;
        end else if (toggle) begin
            q <= ~q;
        end
    end

endmodule

// File: rtl/tff_down_counter.sv
// Loadable synchronous down counter built from T flip-flop cells sharing one
// clock. Each cell's toggle enable is decoded from the lower bits, so there is
// no ripple clocking. Provides zero detect and a registered borrow pulse on
// underflow.
// Optional feature macro: TFF_DOWN_COUNTER_AUTO_RELOAD_EN -- when defined, an
// underflow reloads the last loaded value instead of wrapping to all-ones.
module tff_down_counter
    import tff_down_counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
)(
    input  logic                clk,
    input  logic                clear,
    tff_down_counter_if.slave   bus
);

    logic [WIDTH-1:0] count_reg;
    logic [WIDTH-1:0] toggle;
    logic [WIDTH-1:0] cell_d;
    logic             cell_load;
    logic             underflow;
    logic             borrow_reg;

    // Counting down from zero is the only way to underflow.
    assign underflow = bus.enable && (count_reg == '0);

    // A bit toggles when counting and every lower bit is zero (borrow chain).
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_toggle
            if (gi == 0) begin : g_lsb
                assign toggle[gi] = bus.enable;
            end else begin : g_upper
                assign toggle[gi] = bus.enable && (count_reg[gi-1:0] == '0);
            end
        end
    endgenerate

`ifdef TFF_DOWN_COUNTER_AUTO_RELOAD_EN
    logic [WIDTH-1:0] reload_reg;

    // Remember the most recently loaded value as the underflow reload target.
    always_ff @(posedge clk) begin
        if (clear) begin
            reload_reg <= WIDTH'(RESET_VALUE);
        end else if (bus.load) begin
            reload_reg <= bus.load_value;
        end
    end

    // An underflow is turned into a parallel load of the reload value;
    // an explicit load still takes precedence.
    assign cell_load = bus.load || underflow;
    assign cell_d    = bus.load ? bus.load_value : reload_reg;
`else
    // Without reload, underflow toggles every cell and wraps to all-ones.
    assign cell_load = bus.load;
    assign cell_d    = bus.load_value;
`endif

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
            tff_cell u_cell (
                .clk    (clk),
                .clear  (clear),
                .load   (cell_load),
                .d      (cell_d[gi]),
                .toggle (toggle[gi]),
                .q      (count_reg[gi])
            );
        end
    endgenerate

    // One-cycle borrow pulse on the edge that counts down from zero.
    always_ff @(posedge clk) begin
        if (clear) begin
            borrow_reg <= 1'b0;
        end else if (bus.load) begin
            borrow_reg <= 1'b0;
        end else begin
            borrow_reg <= underflow;
        end
    end

    assign bus.count  = count_reg;
    assign bus.zero   = (count_reg == '0);
    assign bus.borrow = borrow_reg;

endmodule

// File: tb/tb_tff_down_counter.sv
// Directed testbench for tff_down_counter with a scoreboard queue: each step
// pushes the expected post-edge state, then pops and compares after the edge.
module tb_tff_down_counter;

    localparam int W = 4;

    typedef struct {
        string      tag;
        logic [W-1:0] count;
        logic       zero;
        logic       borrow;
    } exp_t;

    logic clk;
    logic clear;

    tff_down_counter_if #(.WIDTH(W)) bus ();

    tff_down_counter #(.WIDTH(W)) dut (
        .clk   (clk),
        .clear (clear),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t         sb[$];
    int           checks;
    int           errors;
    logic [W-1:0] m_count;
    logic         m_borrow;
    logic [W-1:0] m_reload;
    int           obs_pulses;
    int           exp_pulses;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference behaviour of one clock edge, from the counter's definition.
    task automatic model_edge(input logic c, input logic l, input logic [W-1:0] lv, input logic e);
        if (c) begin
            m_count  = '0;
            m_borrow = 1'b0;
            m_reload = '0;
        end else if (l) begin
            m_count  = lv;
            m_borrow = 1'b0;
            m_reload = lv;
        end else if (e) begin
            if (m_count == '0) begin
                m_borrow = 1'b1;
`ifdef TFF_DOWN_COUNTER_AUTO_RELOAD_EN
                m_count  = m_reload;
`else
                m_count  = '1;
`endif
            end else begin
                m_count  = m_count - 1'b1;
                m_borrow = 1'b0;
            end
        end else begin
            m_borrow = 1'b0;
        end
    endtask

    task automatic step(input string tag, input logic c, input logic l,
                        input logic [W-1:0] lv, input logic e);
        exp_t x;
        exp_t got;
        clear          = c;
        bus.load       = l;
        bus.load_value = lv;
        bus.enable     = e;
        model_edge(c, l, lv, e);
        x.tag    = tag;
        x.count  = m_count;
        x.zero   = (m_count == '0);
        x.borrow = m_borrow;
        sb.push_back(x);
        if (m_borrow) exp_pulses++;
        @(posedge clk);
        #1;
        got = sb.pop_front();
        if (bus.borrow === 1'b1) obs_pulses++;
        check({got.tag, ".count"},  32'(bus.count),  32'(got.count));
        check({got.tag, ".zero"},   32'(bus.zero),   32'(got.zero));
        check({got.tag, ".borrow"}, 32'(bus.borrow), 32'(got.borrow));
        $display("step %-10s clr=%0b ld=%0b lv=%0d en=%0b -> count=%0d zero=%0b borrow=%0b",
                 tag, c, l, lv, e, bus.count, bus.zero, bus.borrow);
    endtask

    initial begin
        checks = 0; errors = 0; obs_pulses = 0; exp_pulses = 0;
        m_count = '0; m_borrow = 1'b0; m_reload = '0;
        clear = 1'b0; bus.load = 1'b0; bus.load_value = '0; bus.enable = 1'b0;
        @(negedge clk);

        // 1. Reset and hold
        step("reset", 1, 0, 0, 0);
        check("reset.count_const", 32'(bus.count), 32'd0);
        check("reset.zero_const", 32'(bus.zero), 32'd1);
        for (int i = 0; i < 5; i++) step("hold", 0, 0, 4'd7, 0);

        // 2. Load 3 and count down to zero
        step("load3", 0, 1, 4'd3, 0);
        for (int i = 0; i < 3; i++) step("count", 0, 0, 0, 1);
        check("count.at_zero", 32'(bus.count), 32'd0);

        // 3. Underflow from zero, then a full enabled run
        step("underflow", 0, 0, 0, 1);
`ifndef TFF_DOWN_COUNTER_AUTO_RELOAD_EN
        check("underflow.wrap", 32'(bus.count), 32'hF);
        check("underflow.borrow", 32'(bus.borrow), 32'd1);
`endif
        step("after_uf", 0, 0, 0, 1);
        obs_pulses = 0; exp_pulses = 0;
        for (int i = 0; i < 16; i++) step("run16", 0, 0, 0, 1);
        check("run16.pulses", 32'(obs_pulses), 32'(exp_pulses));
`ifndef TFF_DOWN_COUNTER_AUTO_RELOAD_EN
        check("run16.one_pulse", 32'(obs_pulses), 32'd1);
`endif

        // 4. Load 5 and run two periods
        step("load5", 0, 1, 4'd5, 0);
        for (int i = 0; i < 12; i++) step("run5", 0, 0, 0, 1);

        // 5. Priority: load beats enable at zero; clear beats load
        step("clr", 1, 0, 0, 0);
        step("ld_vs_en", 0, 1, 4'd9, 1);
        check("ld_vs_en.nine", 32'(bus.count), 32'd9);
        step("clr_vs_ld", 1, 1, 4'd12, 1);
        check("clr_vs_ld.zero", 32'(bus.count), 32'd0);

        // 6. Clear in the middle of counting
        step("load10", 0, 1, 4'd10, 0);
        for (int i = 0; i < 3; i++) step("cnt10", 0, 0, 0, 1);
        step("mid_clr", 1, 0, 0, 1);
        step("post_clr", 0, 0, 0, 1);
        step("post_clr2", 0, 0, 0, 1);

        // Scoreboard must be drained
        check("sb.empty", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
